// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: constants and fetch-stage state encoding shared by the RV32IM pipeline
package rv32_pipe_pkg;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// pc_reg: program counter with load enable, word-alignment masking and misalignment pulse
module pc_reg
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q,
    output logic        misaligned
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q          <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            if (load) q <= {d[31:2], 2'b00};
            misaligned <= load && (d[1:0] != 2'b00);
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF stage - PC, instruction-memory handshake and IF/ID register
module fetch_pc_unit
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = rv32_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_busywait,
    input  logic [31:0] imem_readdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_busy,
    output logic        misaligned
);
    fetch_state_t state;
    logic [31:0]  hold_instr;
    logic [31:0]  drain_addr;
    logic         comp;
    logic         pc_load;

    assign imem_read  = (state == S_FETCH) || (state == S_DRAIN);
    assign imem_addr  = (state == S_DRAIN) ? drain_addr : pc;
    assign comp       = imem_read && !imem_busywait;
    assign pc_plus4   = pc + 32'd4;
    assign fetch_busy = (state == S_FETCH && imem_busywait) || state == S_DRAIN || state == S_RESET;
    assign pc_load    = redirect || (state == S_FETCH && comp && !stall) || (state == S_HOLD && !stall);

    pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pc_load),
        .d         (pc_next),
        .q         (pc),
        .misaligned(misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_RESET;
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            drain_addr <= 32'h0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            // an in-flight request must still be retired before the new PC can be fetched
            if (state == S_FETCH && imem_busywait) begin
                state      <= S_DRAIN;
                drain_addr <= pc;
            end else begin
                state <= (state == S_DRAIN && !comp) ? S_DRAIN : S_FETCH;
            end
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_FETCH;
                    if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                    end
                end
                S_FETCH: begin
                    if (comp && stall) begin
                        hold_instr <= imem_readdata;
                        state      <= S_HOLD;
                    end else if (comp) begin
                        ifid_pc    <= pc;
                        ifid_instr <= imem_readdata;
                        ifid_valid <= 1'b1;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_pc    <= pc;
                        ifid_instr <= hold_instr;
                        ifid_valid <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (comp) state <= S_FETCH;
                    if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= NOP_INSTR;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the RV32IM pipeline.
- Holds the program counter and produces PC+4. PC+4 feeds IN0 of the next-PC 2:1 select; the branch target feeds IN1.
- Consumes the selected next PC, drives the instruction-memory read handshake, and fills the IF/ID pipeline register, with stall, redirect/flush and memory-wait handling.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID when it is empty or flushed (addi x0,x0,0).

Ports:
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- PC_NEXT  in  32  selected next PC (PC+4 or branch target)
- REDIRECT  in  1  branch/jump taken in EX; same signal as the next-PC select
- STALL  in  1  hazard unit holds IF/ID (load-use, downstream busy)
- IMEM_BUSYWAIT  in  1  instruction memory not ready
- IMEM_READDATA  in  32  fetched instruction, valid when READ=1 and BUSYWAIT=0
- PC  out  32  current PC
- PC_PLUS4  out  32  PC+32'd4, combinational, wraps modulo 2^32
- IMEM_ADDR  out  32  fetch address (= PC)
- IMEM_READ  out  1  fetch request
- IFID_PC  out  32  PC of instruction in IF/ID
- IFID_INSTR  out  32  instruction in IF/ID
- IFID_VALID  out  1  IF/ID holds a real instruction
- FETCH_BUSY  out  1  fetch cannot deliver this cycle (stall request to pipeline)
- MISALIGNED  out  1  one-cycle pulse: PC_NEXT[1:0]!=0 when loaded

Behaviour:
- Reset (async, RESET_N=0): PC=RESET_VECTOR; IFID_PC=0; IFID_INSTR=NOP_INSTR; IFID_VALID=0; IMEM_READ=0; MISALIGNED=0; hold buffer empty; state=S_RESET. Reset mid-fetch abandons the request with no drain.
- Completion: a rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0.
- S_RESET: IMEM_READ=0; go to S_FETCH on the next edge.
- S_FETCH: IMEM_READ=1, IMEM_ADDR=PC.
  - Completion with STALL=0, REDIRECT=0: IF/ID <= {PC, IMEM_READDATA, valid=1}; PC <= PC_NEXT; stay in S_FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  - Completion with STALL=1: capture the instruction into the hold buffer; PC unchanged; go to S_HOLD.
  - No completion: PC and IF/ID unchanged. If STALL=0, IFID_VALID <= 0 and IFID_INSTR <= NOP (bubble).
- S_HOLD: IMEM_READ=0. When STALL=0: IF/ID <= hold buffer; PC <= PC_NEXT; go to S_FETCH.
- REDIRECT=1 (priority over STALL and completion):
  - PC <= PC_NEXT; IFID_VALID <= 0, IFID_INSTR <= NOP; hold buffer discarded.
  - From S_HOLD: go to S_FETCH.
  - From S_FETCH with a request outstanding (BUSYWAIT=1): go to S_DRAIN.
- S_DRAIN: IMEM_READ=1 with the old address latched. On completion, discard the data and go to S_FETCH, which fetches the new PC. A REDIRECT in S_DRAIN updates PC only.
- FETCH_BUSY = (state==S_FETCH && IMEM_BUSYWAIT) || state==S_DRAIN || state==S_RESET.
- PC load: PC <= {PC_NEXT[31:2],2'b00}. MISALIGNED=1 for the cycle after a load where PC_NEXT[1:0]!=0.
- PC_PLUS4 at 32'hFFFF_FFFC is 32'h0000_0000.
- STALL in S_FETCH without completion keeps the request asserted. IF/ID contents are frozen while STALL=1.

Decomposition:
- Shared package rv32_pipe_pkg:
  - NOP_INSTR constant
  - default RESET_VECTOR
  - fetch_state_t enum: S_RESET, S_FETCH, S_HOLD, S_DRAIN
- One sub-module, pc_reg: 32-bit PC register with load enable, async active-low reset to RESET_VECTOR, alignment masking and MISALIGNED pulse.

Test Plan:
- Reset then zero-wait memory returning instr = addr^32'hA5A5_0000, STALL=0 -> first IFID_VALID=1 at 2nd edge after release with IFID_PC=0; then IFID_PC=0,4,8,C on consecutive cycles.
- BUSYWAIT high 3 cycles on fetch of PC=8 -> IMEM_ADDR stays 8; FETCH_BUSY=1 for 3 cycles; IFID_VALID=0 with NOP; IFID_PC=8 one edge after BUSYWAIT drops.
- STALL=1 for 2 cycles while fetch of PC=C completes -> state S_HOLD, IMEM_READ=0, IF/ID frozen; after release IFID_PC=C and PC=10.
- REDIRECT=1 with PC_NEXT=32'h100 while fetch of PC=14 is busy -> S_DRAIN; returned data discarded; next IMEM_ADDR=100; IFID_VALID=0 until fetch 100 completes.
- REDIRECT and STALL together with PC_NEXT=32'h202 -> PC=200, MISALIGNED pulses 1 cycle, IF/ID flushed to NOP.
- RESET_N asserted mid-S_DRAIN -> all outputs at reset values immediately (async); fetch restarts at RESET_VECTOR.
